weight_feeder: RTL and testbench

// - MAC-side responder to the weight pipeline controller: consumes weight_ctrl/load/busy
//   and writes per-MAC weight registers driven into the systolic MAC array.
// - LOAD command streams words from the weight memory (valid/ready) into masked MACs.
// - LAYER command shifts weights from the lower half of the array to the upper half.

---
 rtl/weight_feeder.sv | 200 ++++++++++++++++++++
 tb/tb_weight_feeder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/weight_feeder.sv
// weight_feeder: fills per-MAC weight registers from the weight memory (LOAD) and copies
// the lower half of the MAC array into the upper half (LAYER). Option: WEIGHT_FEEDER_PARITY_EN.
module weight_feeder #(
    parameter int N_MACS = 4,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_MACS-1:0]          weight_ctrl,
    input  logic [2:0]                 load,
    input  logic                       busy,
    input  logic [DATA_W-1:0]          w_data,
    input  logic                       w_valid,
`ifdef WEIGHT_FEEDER_PARITY_EN
    input  logic                       w_par,
`endif
    output logic                       w_ready,
    output logic [N_MACS*DATA_W-1:0]   mac_weight,
    output logic [N_MACS-1:0]          mac_weight_valid,
    output logic                       load_done,
    output logic                       err
);
    localparam int HALF  = N_MACS / 2;
    localparam int CNT_W = $clog2(N_MACS) + 1;
    localparam int IDX_W = (N_MACS > 1) ? $clog2(N_MACS) : 1;
    localparam logic [N_MACS-1:0] ONE_M = {{(N_MACS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [2:0]                prev_load_q, prev_load_d;
    logic [N_MACS-1:0]         rem_q, rem_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]          total_q, total_d;
    logic [N_MACS*DATA_W-1:0]  weight_q, weight_d;
    logic [N_MACS-1:0]         valid_q, valid_d;
    logic                      w_ready_q, w_ready_d;
    logic                      load_done_q, load_done_d;
    logic                      err_q, err_d;

    logic                      fire_s;
    logic                      is_load_s;
    logic                      is_layer_s;
    logic                      bad_code_s;
    logic                      par_ok_s;
    logic [IDX_W-1:0]          low_idx_s;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_MACS-1:0] m);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_MACS; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, m[i]};
        end
        return c;
    endfunction

`ifdef WEIGHT_FEEDER_PARITY_EN
    function automatic logic even_parity_ok(input logic [DATA_W-1:0] d, input logic p);
        return ~((^d) ^ p);
    endfunction
`endif

    // Command edge detect and parity status of the offered word.
    always_comb begin
        fire_s     = (load != prev_load_q) && (load != 3'b000) && busy;
        is_load_s  = (load == 3'b001);
        is_layer_s = (load == 3'b010);
        bad_code_s = fire_s && !is_load_s && !is_layer_s;
        prev_load_d = load;
`ifdef WEIGHT_FEEDER_PARITY_EN
        par_ok_s = even_parity_ok(w_data, w_par);
`else
        par_ok_s = 1'b1;
`endif
    end

    // Lowest still-unwritten masked MAC: words land in ascending index order.
    always_comb begin
        low_idx_s = '0;
        for (int i = N_MACS - 1; i >= 0; i--) begin
            low_idx_s = rem_q[i] ? IDX_W'(i) : low_idx_s;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        total_d     = total_q;
        weight_d    = weight_q;
        valid_d     = valid_q;
        w_ready_d   = w_ready_q;
        load_done_d = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                w_ready_d = 1'b0;
                if (bad_code_s) begin
                    err_d = 1'b1;
                end else if (fire_s && is_load_s) begin
                    if (weight_ctrl == '0) begin
                        load_done_d = 1'b1;
                    end else begin
                        rem_d     = weight_ctrl;
                        cnt_d     = '0;
                        total_d   = popcount(weight_ctrl);
                        valid_d   = valid_q & ~weight_ctrl;
                        w_ready_d = 1'b1;
                        state_d   = S_FILL;
                    end
                end else if (fire_s && is_layer_s) begin
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (!busy) begin
                    // Abort: written words keep their valid bits.
                    state_d   = S_IDLE;
                    w_ready_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    err_d = fire_s;
                    if (w_valid && w_ready_q) begin
                        if (!par_ok_s) begin
                            err_d = 1'b1;
                        end else begin
                            weight_d[int'(low_idx_s)*DATA_W +: DATA_W] = w_data;
                            valid_d[low_idx_s] = 1'b1;
                            rem_d = rem_q & (rem_q - ONE_M);
                            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                            if ((cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}) == total_q) begin
                                state_d     = S_IDLE;
                                w_ready_d   = 1'b0;
                                load_done_d = 1'b1;
                            end else begin
                                state_d = S_FILL;
                            end
                        end
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_SHIFT: begin
                err_d = fire_s;
                for (int i = HALF; i < N_MACS; i++) begin
                    weight_d[i*DATA_W +: DATA_W] = weight_ctrl[i] ?
                        weight_q[(i-HALF)*DATA_W +: DATA_W] : weight_q[i*DATA_W +: DATA_W];
                    valid_d[i] = weight_ctrl[i] ? valid_q[i-HALF] : valid_q[i];
                end
                load_done_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                w_ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prev_load_q <= 3'b000;
            rem_q       <= '0;
            cnt_q       <= '0;
            total_q     <= '0;
            weight_q    <= '0;
            valid_q     <= '0;
            w_ready_q   <= 1'b0;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_load_q <= prev_load_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            total_q     <= total_d;
            weight_q    <= weight_d;
            valid_q     <= valid_d;
            w_ready_q   <= w_ready_d;
            load_done_q <= load_done_d;
            err_q       <= err_d;
        end
    end

    assign w_ready          = w_ready_q;
    assign mac_weight       = weight_q;
    assign mac_weight_valid = valid_q;
    assign load_done        = load_done_q;
    assign err              = err_q;
endmodule

// File: tb/tb_weight_feeder.sv
// Scoreboard bench for weight_feeder: expected load_done/err events are queued by the
// stimulus and popped by a negedge monitor whenever the DUT pulses one of them.
module tb_weight_feeder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  weight_ctrl = 4'b0000;
    logic [2:0]  load = 3'b000;
    logic        busy = 1'b0;
    logic [7:0]  w_data = 8'h00;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [31:0] mac_weight;
    logic [3:0]  mac_weight_valid;
    logic        load_done;
    logic        err;
`ifdef WEIGHT_FEEDER_PARITY_EN
    logic        par_flip = 1'b0;
    logic        w_par;
    assign w_par = (^w_data) ^ par_flip;
`endif

    typedef struct {
        logic        done;
        logic        err;
        logic [31:0] w;
        logic [3:0]  v;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    weight_feeder #(.N_MACS(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .weight_ctrl(weight_ctrl), .load(load), .busy(busy),
        .w_data(w_data), .w_valid(w_valid),
`ifdef WEIGHT_FEEDER_PARITY_EN
        .w_par(w_par),
`endif
        .w_ready(w_ready), .mac_weight(mac_weight), .mac_weight_valid(mac_weight_valid),
        .load_done(load_done), .err(err)
    );

    always #5 clk = ~clk;

    // Monitor: each load_done/err pulse is matched against the oldest expected event.
    always @(negedge clk) begin
        if (!rst && (load_done || err)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got done=%0b err=%0b w=%h v=%b, required none",
                         load_done, err, mac_weight, mac_weight_valid);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.done !== load_done || e.err !== err || e.w !== mac_weight ||
                    e.v !== mac_weight_valid) begin
                    n_fail++;
                    $display("FAIL event: got done=%0b err=%0b w=%h v=%b, required done=%0b err=%0b w=%h v=%b",
                             load_done, err, mac_weight, mac_weight_valid, e.done, e.err, e.w, e.v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic d, input logic e, input logic [31:0] w, input logic [3:0] v);
        ev_t x;
        x.done = d; x.err = e; x.w = w; x.v = v;
        exp_q.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic send_word(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        w_data  = d;
        w_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (w_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL handshake_timeout: got w_ready=0, required 1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        w_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_w"},     mac_weight, 32'h0);
        check({tag, "_v"},     {28'h0, mac_weight_valid}, 32'h0);
        check({tag, "_rdy"},   {31'h0, w_ready}, 32'h0);
        check({tag, "_done"},  {31'h0, load_done}, 32'h0);
        check({tag, "_err"},   {31'h0, err}, 32'h0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        tick(); tick();
        rst  = 1'b0;
        busy = 1'b1;
        tick();

        // LOAD mask 0011, words 0x11, 0x22
        load = 3'b001; weight_ctrl = 4'b0011;
        tick();
        send_word(8'h11);
        expect_ev(1'b1, 1'b0, 32'h0000_2211, 4'b0011);
        send_word(8'h22);
        load = 3'b000;
        tick();
        check("ready_low_after_load", {31'h0, w_ready}, 32'h0);

        // LAYER mask 1100: lower half copied up
        expect_ev(1'b1, 1'b0, 32'h2211_2211, 4'b1111);
        load = 3'b010; weight_ctrl = 4'b1100;
        tick(); tick();
        load = 3'b000;
        tick();

        // LOAD mask 0011 with w_valid 1,0,1
        load = 3'b001; weight_ctrl = 4'b0011;
        tick();
        send_word(8'h33);
        tick(); tick();
        expect_ev(1'b1, 1'b0, 32'h2211_4433, 4'b1111);
        send_word(8'h44);
        load = 3'b000;
        tick();

        // Abort after 1 of 2 words
        load = 3'b001; weight_ctrl = 4'b0011;
        tick();
        send_word(8'h55);
        expect_ev(1'b0, 1'b1, 32'h2211_4455, 4'b1101);
        busy = 1'b0;
        tick();
        check("ready_low_after_abort", {31'h0, w_ready}, 32'h0);
        load = 3'b000; busy = 1'b1;
        tick();

        // Illegal code 011
        expect_ev(1'b0, 1'b1, 32'h2211_4455, 4'b1101);
        load = 3'b011;
        tick();
        load = 3'b000;
        tick();

        // LAYER edge during FILL is dropped, fill completes
        load = 3'b001; weight_ctrl = 4'b0100;
        tick();
        expect_ev(1'b0, 1'b1, 32'h2211_4455, 4'b1001);
        load = 3'b010;
        tick();
        expect_ev(1'b1, 1'b0, 32'h2266_4455, 4'b1101);
        send_word(8'h66);
        load = 3'b000;
        tick();

        // LOAD with empty mask completes at once
        expect_ev(1'b1, 1'b0, 32'h2266_4455, 4'b1101);
        load = 3'b001; weight_ctrl = 4'b0000;
        tick();
        load = 3'b000;
        tick();

`ifdef WEIGHT_FEEDER_PARITY_EN
        // Bad parity on 2nd word: consumed, not written, retried
        load = 3'b001; weight_ctrl = 4'b0011;
        tick();
        send_word(8'h11);
        expect_ev(1'b0, 1'b1, 32'h2266_4411, 4'b1101);
        par_flip = 1'b1;
        send_word(8'h99);
        par_flip = 1'b0;
        expect_ev(1'b1, 1'b0, 32'h2266_2211, 4'b1111);
        send_word(8'h22);
        load = 3'b000;
        tick();
`endif

        // Async reset mid-FILL
        load = 3'b001; weight_ctrl = 4'b1111;
        tick();
        send_word(8'h77);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        load = 3'b000;
        tick();
        rst = 1'b0;
        tick(); tick();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
